// File: rtl/bcd_subtractor_serial_pkg.sv
// Shared definitions for the digit-serial BCD subtractor.
//   state_t    : control FSM states (IDLE, CALC)
//   BCD_MAX    : largest legal BCD digit value
//   BCD_RADIX  : decimal radix used for borrow correction
//   DIGIT_W    : bits per packed BCD digit
//   idx_width  : digit index counter width, never below 1
package bcd_subtractor_serial_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  localparam int unsigned BCD_MAX   = 9;
  localparam int unsigned BCD_RADIX = 10;
  localparam int unsigned DIGIT_W   = 4;

  function automatic int unsigned idx_width(input int unsigned digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/bcd_subtractor_serial_digit_sub.sv
// bcd_digit_sub: combinational single-digit BCD subtract cell, d = a - b - bin.
//   a, b : BCD digits (0..9)
//   bin  : borrow in
//   d    : BCD result digit
//   bout : borrow out (raw difference was negative)
module bcd_digit_sub
  import bcd_subtractor_serial_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout
);

  logic [4:0] t;
  logic [4:0] t_corr;

  // 5-bit two's complement difference lies in -10..9 for legal digits
  always_comb begin
    t      = 5'(a) - 5'(b) - 5'(bin);
    t_corr = t + 5'(BCD_RADIX);
    bout   = t[4];
    d      = bout ? t_corr[3:0] : t[3:0];
  end

endmodule

// File: rtl/bcd_subtractor_serial.sv
// bcd_subtractor_serial: digit-serial D = A - B - b0, LSD first, one digit per clock.
//   clk, rst_n : clock, async active-low reset
//   start      : request, sampled only in IDLE
//   A, B, b0   : packed BCD minuend, subtrahend, borrow-in
//   busy       : subtraction in progress
//   done       : one-cycle completion pulse
//   D          : packed BCD result (ten's complement when borrow_out)
//   borrow_out : final borrow
//   invalid    : last accepted request had a digit above 9
module bcd_subtractor_serial
  import bcd_subtractor_serial_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   A,
  input  logic [4*DIGITS-1:0]   B,
  input  logic                  b0,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   D,
  output logic                  borrow_out,
  output logic                  invalid
);

  localparam int unsigned W     = DIGIT_W * DIGITS;
  localparam int unsigned IDX_W = idx_width(DIGITS);

  state_t           state, state_nxt;
  logic [W-1:0]     a_sh, a_sh_nxt;
  logic [W-1:0]     b_sh, b_sh_nxt;
  logic [W-1:0]     acc, acc_nxt;
  logic             borrow_r, borrow_r_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             busy_nxt, done_nxt, borrow_out_nxt, invalid_nxt;
  logic [W-1:0]     d_nxt;

  logic             ops_ok_c;
  logic [3:0]       cell_d;
  logic             cell_bout;
  logic [W+3:0]     acc_ext;
  logic [W-1:0]     acc_shift;

  // Per-cycle datapath: low digit of each operand shift register
  bcd_digit_sub u_cell (
    .a    (a_sh[3:0]),
    .b    (b_sh[3:0]),
    .bin  (borrow_r),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // New digit enters at the top; after DIGITS cycles digit 0 sits at [3:0]
  always_comb begin
    acc_ext   = {cell_d, acc};
    acc_shift = acc_ext[W+3:DIGIT_W];
  end

  // Every digit of both operands must be a legal BCD digit
  always_comb begin
    ops_ok_c = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (A[DIGIT_W*i +: DIGIT_W] > 4'(BCD_MAX) || B[DIGIT_W*i +: DIGIT_W] > 4'(BCD_MAX)) begin
        ops_ok_c = 1'b0;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state, datapath and output logic
  always_comb begin
    state_nxt      = state;
    a_sh_nxt       = a_sh;
    b_sh_nxt       = b_sh;
    acc_nxt        = acc;
    borrow_r_nxt   = borrow_r;
    idx_nxt        = idx;
    busy_nxt       = busy;
    done_nxt       = 1'b0;
    d_nxt          = D;
    borrow_out_nxt = borrow_out;
    invalid_nxt    = invalid;

    case (state)
      IDLE: begin
        if (start) begin
          if (ops_ok_c) begin
            a_sh_nxt     = A;
            b_sh_nxt     = B;
            acc_nxt      = '0;
            borrow_r_nxt = b0;
            idx_nxt      = '0;
            busy_nxt     = 1'b1;
            state_nxt    = CALC;
          end else begin
            d_nxt          = '0;
            borrow_out_nxt = 1'b0;
            invalid_nxt    = 1'b1;
            done_nxt       = 1'b1;
          end
        end
      end
      CALC: begin
        a_sh_nxt     = a_sh >> DIGIT_W;
        b_sh_nxt     = b_sh >> DIGIT_W;
        acc_nxt      = acc_shift;
        borrow_r_nxt = cell_bout;
        idx_nxt      = idx + IDX_W'(1);
        if (idx == IDX_W'(DIGITS - 1)) begin
          idx_nxt        = '0;
          d_nxt          = acc_shift;
          borrow_out_nxt = cell_bout;
          invalid_nxt    = 1'b0;
          done_nxt       = 1'b1;
          busy_nxt       = 1'b0;
          state_nxt      = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // Working and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      acc        <= '0;
      borrow_r   <= 1'b0;
      idx        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      D          <= '0;
      borrow_out <= 1'b0;
      invalid    <= 1'b0;
    end else begin
      a_sh       <= a_sh_nxt;
      b_sh       <= b_sh_nxt;
      acc        <= acc_nxt;
      borrow_r   <= borrow_r_nxt;
      idx        <= idx_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      D          <= d_nxt;
      borrow_out <= borrow_out_nxt;
      invalid    <= invalid_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_subtractor_serial.sv
// Scoreboard bench for bcd_subtractor_serial: a 4-digit instance for directed
// scenarios and a 1-digit instance swept over every nibble pair and borrow-in.
module tb_bcd_subtractor_serial;

  typedef struct packed {
    logic [15:0] d;
    logic        bo;
    logic        inv;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start4, start1;
  logic [15:0] a4, b4;
  logic [3:0]  a1, b1;
  logic        bi4, bi1;
  logic        busy4, done4, bo4, inv4;
  logic        busy1, done1, bo1, inv1;
  logic [15:0] d4;
  logic [3:0]  d1;

  exp_t q4[$];
  exp_t q1[$];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bcd_subtractor_serial #(.DIGITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4), .b0(bi4),
    .busy(busy4), .done(done4), .D(d4), .borrow_out(bo4), .invalid(inv4)
  );

  bcd_subtractor_serial #(.DIGITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .A(a1), .B(b1), .b0(bi1),
    .busy(busy1), .done(done1), .D(d1), .borrow_out(bo1), .invalid(inv1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: pop one expectation per done pulse
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done4 === 1'b1) begin
        if (q4.size() == 0) chk("done4_unexpected", 32'(done4), 32'd0);
        else begin
          e = q4.pop_front();
          chk("d4", 32'(d4), 32'(e.d));
          chk("borrow4", 32'(bo4), 32'(e.bo));
          chk("invalid4", 32'(inv4), 32'(e.inv));
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done1 === 1'b1) begin
        if (q1.size() == 0) chk("done1_unexpected", 32'(done1), 32'd0);
        else begin
          e = q1.pop_front();
          chk("d1", 32'(d1), 32'(e.d));
          chk("borrow1", 32'(bo1), 32'(e.bo));
          chk("invalid1", 32'(inv1), 32'(e.inv));
          chk("d1_le9", 32'(d1 <= 4'd9), 32'd1);
        end
      end
    end
  end

  // One 4-digit operation with busy-window checks; returns in the done cycle
  task automatic op4(input logic [15:0] a, input logic [15:0] b, input logic bi,
                     input logic [15:0] ed, input logic ebo);
    exp_t e;
    @(negedge clk);
    start4 = 1'b1; a4 = a; b4 = b; bi4 = bi;
    e.d = ed; e.bo = ebo; e.inv = 1'b0;
    q4.push_back(e);
    @(posedge clk);
    #1 start4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("busy4_high", 32'(busy4), 32'd1);
    end
    @(negedge clk);
    chk("busy4_low_at_done", 32'(busy4), 32'd0);
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bi4 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; bi1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy4), 32'd0);
    chk("rst_done", 32'(done4), 32'd0);
    chk("rst_d", 32'(d4), 32'd0);
    chk("rst_borrow", 32'(bo4), 32'd0);
    chk("rst_invalid", 32'(inv4), 32'd0);
    rst_n = 1'b1;

    // Basic, negative wrap-around, borrow-in wrap
    op4(16'h4321, 16'h1234, 1'b0, 16'h3087, 1'b0);
    op4(16'h0000, 16'h0001, 1'b0, 16'h9999, 1'b1);
    op4(16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1);

    // Illegal digit: immediate done with invalid, no busy
    @(negedge clk);
    start4 = 1'b1; a4 = 16'h12A4; b4 = 16'h0000; bi4 = 1'b0;
    e.d = 16'h0000; e.bo = 1'b0; e.inv = 1'b1;
    q4.push_back(e);
    @(posedge clk);
    #1 start4 = 1'b0;
    @(negedge clk);
    chk("inv_busy_low", 32'(busy4), 32'd0);
    chk("inv_done_high", 32'(done4), 32'd1);
    @(negedge clk);
    chk("inv_busy_still_low", 32'(busy4), 32'd0);
    op4(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0);

    // start held through CALC with changing operands; re-accepted in the done cycle
    @(negedge clk);
    start4 = 1'b1; a4 = 16'h5000; b4 = 16'h0001; bi4 = 1'b0;
    e.d = 16'h4999; e.bo = 1'b0; e.inv = 1'b0;
    q4.push_back(e);
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a4 = 16'h9999 - 16'(i); b4 = (i == 2) ? 16'h00A0 : 16'h1111; bi4 = 1'(i);
    end
    @(negedge clk);
    chk("held_done", 32'(done4), 32'd1);
    a4 = 16'h0777; b4 = 16'h0555; bi4 = 1'b0;
    e.d = 16'h0222; e.bo = 1'b0; e.inv = 1'b0;
    q4.push_back(e);
    @(posedge clk);
    #1 start4 = 1'b0;
    @(negedge clk);
    chk("held_reaccept_busy", 32'(busy4), 32'd1);
    repeat (6) @(negedge clk);

    // Reset in mid-CALC abandons the operation
    @(negedge clk);
    start4 = 1'b1; a4 = 16'h8642; b4 = 16'h0123; bi4 = 1'b0;
    @(posedge clk);
    #1 start4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy4), 32'd0);
    chk("arst_done", 32'(done4), 32'd0);
    chk("arst_d", 32'(d4), 32'd0);
    chk("arst_borrow", 32'(bo4), 32'd0);
    chk("arst_invalid", 32'(inv4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    op4(16'h8642, 16'h0123, 1'b0, 16'h8519, 1'b0);

    // 1-digit sweep over every nibble pair and borrow-in
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int bi = 0; bi < 2; bi++) begin
          int r;
          @(negedge clk);
          start1 = 1'b1; a1 = 4'(a); b1 = 4'(b); bi1 = 1'(bi);
          if (a > 9 || b > 9) begin
            e.d = 16'h0; e.bo = 1'b0; e.inv = 1'b1;
          end else begin
            r = a - b - bi;
            e.bo = (r < 0);
            if (r < 0) r = r + 10;
            e.d = 16'(r); e.inv = 1'b0;
          end
          q1.push_back(e);
          @(posedge clk);
          #1 start1 = 1'b0;
          @(posedge clk);
        end
      end
    end

    // Drain with a bounded wait
    begin
      int budget = 50;
      while ((q4.size() != 0 || q1.size() != 0) && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (q4.size() != 0 || q1.size() != 0) begin
        chk("drain_pending", 32'(q4.size() + q1.size()), 32'd0);
      end
      repeat (2) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
